hci_mem_responder: RTL and testbench

Target-side responder for the HCI core interface: it accepts the TCDM requests that an HWPE subsystem issues on its `hci_core_intf` initiator port and answers them from a single-ported, word-addressed local memory. Read responses go through a small response FIFO with `r_ready` backpressure. An optional LFSR-driven grant-stall generator exercises initiator retry behaviour. The block serves as a TCDM bank stand-in for HWPE-level integration benches and as a scratch memory behind the HWPE crossbar.

---
 rtl/hci_mem_responder.sv | 152 +++++++++++++++
 tb/tb_hci_mem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_mem_responder.sv
// TCDM-style target: answers HCI core requests from a word-addressed local memory,
// with a read-response FIFO (r_ready backpressure) and an optional LFSR grant-stall generator.
module hci_mem_responder #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned UW         = 1,
  parameter int unsigned IW         = 8,
  parameter int unsigned EW         = 0,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned RESP_DEPTH = 2,
  parameter logic [15:0] STALL_MASK = 16'h0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        tcdm_req,
  output logic                        tcdm_gnt,
  input  logic [AW-1:0]               tcdm_add,
  input  logic                        tcdm_wen,
  input  logic [DW-1:0]               tcdm_data,
  input  logic [DW/8-1:0]             tcdm_be,
  input  logic [UW-1:0]               tcdm_user,
  input  logic [IW-1:0]               tcdm_id,
  output logic [DW-1:0]               tcdm_r_data,
  output logic                        tcdm_r_valid,
  input  logic                        tcdm_r_ready,
  output logic                        tcdm_r_opc,
  output logic [UW-1:0]               tcdm_r_user,
  output logic [IW-1:0]               tcdm_r_id,
  output logic                        tcdm_egnt,
  output logic                        tcdm_r_evalid,
  output logic [(EW > 0 ? EW : 1)-1:0] tcdm_r_ecc,
  output logic [15:0]                 err_cnt_o
);

  localparam int unsigned BW     = DW / 8;
  localparam int unsigned BSHIFT = (BW > 1) ? $clog2(BW) : 0;
  localparam int unsigned IDXW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned PW     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW     = $clog2(RESP_DEPTH + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  logic [DW-1:0]   mem [NUM_WORDS];
  logic [DW-1:0]   fifo_data [RESP_DEPTH];
  logic [IW-1:0]   fifo_id   [RESP_DEPTH];
  logic [UW-1:0]   fifo_user [RESP_DEPTH];
  logic            fifo_opc  [RESP_DEPTH];

  logic [15:0]     lfsr;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr, wr_ptr;

  logic [AW-1:0]   offset, word_idx;
  logic [IDXW-1:0] mem_idx;
  logic            in_range, stall, accept, push, pop, mem_we;
  logic [DW-1:0]   rd_word, bmask;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Address decode; addresses below BASE_ADDR wrap to a huge index and fall out of range
  always_comb begin
    offset   = tcdm_add - BASE_ADDR;
    word_idx = offset >> BSHIFT;
    in_range = (word_idx < AW'(NUM_WORDS));
    mem_idx  = word_idx[IDXW-1:0];
    rd_word  = in_range ? mem[mem_idx] : '0;
  end

  // Grant does not look at req/wen, so a full FIFO also holds off writes unless it is draining
  always_comb begin
    stall        = (STALL_MASK != 16'h0) && ((lfsr & STALL_MASK) == 16'h0);
    tcdm_r_valid = (count != '0);
    pop          = tcdm_r_valid && tcdm_r_ready;
    tcdm_gnt     = !rst_i && !clear_i && !stall && ((count < CW'(RESP_DEPTH)) || pop);
    accept       = tcdm_req && tcdm_gnt;
    push         = accept && tcdm_wen;
    mem_we       = accept && !tcdm_wen && in_range;
  end

  for (genvar b = 0; b < BW; b++) begin : g_bmask
    assign bmask[8*b +: 8] = {8{tcdm_be[b]}};
  end

  // Head of the response FIFO; fields read as zero while empty
  always_comb begin
    tcdm_r_data   = tcdm_r_valid ? fifo_data[rd_ptr] : '0;
    tcdm_r_id     = tcdm_r_valid ? fifo_id[rd_ptr]   : '0;
    tcdm_r_user   = tcdm_r_valid ? fifo_user[rd_ptr] : '0;
    tcdm_r_opc    = tcdm_r_valid ? fifo_opc[rd_ptr]  : 1'b0;
    tcdm_egnt     = 1'b0;
    tcdm_r_evalid = 1'b0;
    tcdm_r_ecc    = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else if (clear_i) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  // FIFO bookkeeping; simultaneous push and pop keep the occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_word;
      fifo_id[wr_ptr]   <= tcdm_id;
      fifo_user[wr_ptr] <= tcdm_user;
      fifo_opc[wr_ptr]  <= !in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_idx] <= (rd_word & ~bmask) | (tcdm_data & bmask);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= 16'h0;
    end else if (accept && !in_range && (err_cnt_o != 16'hFFFF)) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_hci_mem_responder.sv
// Bench for hci_mem_responder: queue/array reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hci_mem_responder;

  localparam int unsigned NW    = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 2;
  localparam logic [15:0] MASK  = 16'h0003;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] add = '0;
  logic        wen = 1'b0;
  logic [31:0] data = '0;
  logic [3:0]  be = '0;
  logic [3:0]  user = '0;
  logic [7:0]  id = '0;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic        r_opc;
  logic [3:0]  r_user;
  logic [7:0]  r_id;
  logic        egnt, r_evalid;
  logic [0:0]  r_ecc;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  hci_mem_responder #(
    .DW(32), .AW(32), .UW(4), .IW(8), .EW(0),
    .NUM_WORDS(NW), .BASE_ADDR(BASE), .RESP_DEPTH(DEPTH), .STALL_MASK(MASK)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add), .tcdm_wen(wen),
    .tcdm_data(data), .tcdm_be(be), .tcdm_user(user), .tcdm_id(id),
    .tcdm_r_data(r_data), .tcdm_r_valid(r_valid), .tcdm_r_ready(r_ready),
    .tcdm_r_opc(r_opc), .tcdm_r_user(r_user), .tcdm_r_id(r_id),
    .tcdm_egnt(egnt), .tcdm_r_evalid(r_evalid), .tcdm_r_ecc(r_ecc),
    .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  id;
    logic [3:0]  user;
    logic        opc;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] mmem [NW];
  logic [15:0] mlfsr = SEED;
  int          merr = 0;
  logic [31:0] popped[$];
  int          errors = 0;
  int          checks = 0;
  logic        rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int v, fb;
    v  = int'(l);
    fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (fb << 15));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off / 4 >= longint'(NW)) return -1;
    return int'(off / 4);
  endfunction

  function automatic logic exp_gnt();
    int n;
    n = rq.size();
    return !clear && ((mlfsr & MASK) != 16'h0) && (n < int'(DEPTH) || (n > 0 && r_ready));
  endfunction

  function automatic logic [31:0] waddr(input int w);
    return BASE + 32'(w * 4);
  endfunction

  // Reference model: one transaction-level step per clock
  always @(posedge clk or posedge rst) begin : model
    logic g;
    int w;
    resp_t r;
    if (rst) begin
      rq.delete();
      mlfsr = SEED;
      merr = 0;
    end else begin
      g = exp_gnt();
      if (clear) begin
        rq.delete();
        mlfsr = SEED;
      end else begin
        mlfsr = lfsr_next(mlfsr);
        if (rq.size() > 0 && r_ready) void'(rq.pop_front());
        if (req && g) begin
          w = word_of(add);
          if (w < 0 && merr < 65535) merr = merr + 1;
          if (wen) begin
            r.data = (w < 0) ? 32'h0 : mmem[w];
            r.opc  = (w < 0);
            r.id   = id;
            r.user = user;
            rq.push_back(r);
          end else if (w >= 0) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) mmem[w][8*b +: 8] = data[8*b +: 8];
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    if (rst) begin
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_r_valid", 64'(r_valid), 64'(0));
      chk("rst_r_fields", 64'({r_data, r_id, r_user, r_opc}), 64'(0));
      chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    end else begin
      chk("gnt", 64'(gnt), 64'(exp_gnt()));
      chk("r_valid", 64'(r_valid), 64'(rq.size() > 0));
      if (rq.size() > 0) begin
        chk("r_data", 64'(r_data), 64'(rq[0].data));
        chk("r_id", 64'(r_id), 64'(rq[0].id));
        chk("r_user", 64'(r_user), 64'(rq[0].user));
        chk("r_opc", 64'(r_opc), 64'(rq[0].opc));
      end else begin
        chk("r_idle_fields", 64'({r_data, r_id, r_user, r_opc}), 64'(0));
      end
      chk("err_cnt", 64'(err_cnt), 64'(merr));
      chk("ecc_outs", 64'({egnt, r_evalid, r_ecc}), 64'(0));
      if (r_valid && r_ready) popped.push_back(r_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Present one request and hold it until granted (bounded)
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [7:0] i, input logic [3:0] u);
    int t;
    logic g;
    req = 1'b1; wen = w; add = a; data = d; be = b; id = i; user = u;
    t = 0;
    g = 1'b0;
    while (!g && t < 100) begin
      @(negedge clk);
      g = gnt;
      cyc();
      t++;
      if (rand_rdy) r_ready = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    if (!g) chk("access_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    int t;
    r_ready = 1'b1;
    t = 0;
    while (r_valid && t < 20) begin
      cyc();
      t++;
    end
    chk("drain_empty", 64'(r_valid), 64'(0));
    r_ready = 1'b0;
  endtask

  // First gnt values after a reseed with an empty FIFO: lfsr ACE1,5670,AB38,559C,2ACE
  task automatic check_seed_pattern(input string nm);
    logic [4:0] pat;
    pat = 5'b10001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(nm, 64'(gnt), 64'(pat[i]));
      chk({nm, "_r_valid"}, 64'(r_valid), 64'(0));
      cyc();
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int t;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 64'(gnt), 64'(0));
    chk("reset_err", 64'(err_cnt), 64'(0));
    #1 rst = 1'b0;
    check_seed_pattern("seed_gnt");

    for (int w = 0; w < int'(NW); w++)
      access(1'b0, waddr(w), 32'hC0DE_0000 | 32'(w), 4'hF, 8'h0, 4'h0);

    // Basic byte-enable write then read
    access(1'b0, waddr(5), 32'hDEAD_BEEF, 4'hF, 8'h0, 4'h0);
    access(1'b0, waddr(5), 32'h0000_00AA, 4'h1, 8'h0, 4'h0);
    access(1'b1, waddr(5), 32'h0, 4'h0, 8'h3C, 4'h9);
    @(negedge clk);
    chk("basic_r_valid", 64'(r_valid), 64'(1));
    chk("basic_r_data", 64'(r_data), 64'(32'hDEAD_BEAA));
    chk("basic_r_opc", 64'(r_opc), 64'(0));
    chk("basic_r_id", 64'(r_id), 64'(8'h3C));
    chk("basic_r_user", 64'(r_user), 64'(4'h9));
    drain();

    // Backpressure: two reads fill the FIFO, the third is held off
    popped.delete();
    access(1'b1, waddr(0), 32'h0, 4'h0, 8'd0, 4'h0);
    access(1'b1, waddr(1), 32'h0, 4'h0, 8'd1, 4'h0);
    req = 1'b1; wen = 1'b1; add = waddr(2); id = 8'd2;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt) n++;
      cyc();
    end
    chk("bp_gnt_low", 64'(n), 64'(0));
    chk("bp_head_hold", 64'(r_data), 64'(32'hC0DE_0000));
    r_ready = 1'b1;
    access(1'b1, waddr(2), 32'h0, 4'h0, 8'd2, 4'h0);
    access(1'b1, waddr(3), 32'h0, 4'h0, 8'd3, 4'h0);
    t = 0;
    while (popped.size() < 4 && t < 30) begin
      cyc();
      t++;
    end
    chk("bp_pop_count", 64'(popped.size()), 64'(4));
    for (int k = 0; k < 4 && k < popped.size(); k++)
      chk("bp_order", 64'(popped[k]), 64'(32'hC0DE_0000 | 32'(k)));
    drain();

    // Out-of-range accesses and range boundaries
    access(1'b1, BASE + 32'(NW * 4), 32'h0, 4'h0, 8'd7, 4'h0);
    @(negedge clk);
    chk("oor_r_valid", 64'(r_valid), 64'(1));
    chk("oor_r_data", 64'(r_data), 64'(0));
    chk("oor_r_opc", 64'(r_opc), 64'(1));
    chk("oor_err1", 64'(err_cnt), 64'(1));
    drain();
    access(1'b0, BASE + 32'(NW * 4), 32'hFFFF_FFFF, 4'hF, 8'd0, 4'h0);
    @(negedge clk);
    chk("oor_err2", 64'(err_cnt), 64'(2));
    access(1'b1, waddr(0), 32'h0, 4'h0, 8'd8, 4'h0);
    @(negedge clk);
    chk("oor_mem_kept", 64'(r_data), 64'(32'hC0DE_0000));
    drain();
    access(1'b1, waddr(int'(NW) - 1), 32'h0, 4'h0, 8'd9, 4'h0);
    @(negedge clk);
    chk("last_word_data", 64'(r_data), 64'(32'hC0DE_003F));
    chk("last_word_opc", 64'(r_opc), 64'(0));
    drain();
    access(1'b1, BASE - 32'd4, 32'h0, 4'h0, 8'd10, 4'h0);
    @(negedge clk);
    chk("below_base_opc", 64'(r_opc), 64'(1));
    chk("below_base_err", 64'(err_cnt), 64'(3));
    drain();

    // Reset with two responses queued
    access(1'b1, waddr(1), 32'h0, 4'h0, 8'd11, 4'h0);
    access(1'b1, waddr(2), 32'h0, 4'h0, 8'd12, 4'h0);
    cyc();
    chk("pre_rst_valid", 64'(r_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(r_valid), 64'(0));
    chk("rst_async_gnt", 64'(gnt), 64'(0));
    chk("rst_async_err", 64'(err_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check_seed_pattern("post_rst_gnt");

    // Clear with one response queued
    access(1'b1, waddr(5), 32'h0, 4'h0, 8'h55, 4'h0);
    @(negedge clk);
    chk("pre_clear_valid", 64'(r_valid), 64'(1));
    cyc();
    clear = 1'b1;
    @(negedge clk);
    chk("clear_gnt", 64'(gnt), 64'(0));
    cyc();
    clear = 1'b0;
    @(negedge clk);
    chk("post_clear_valid", 64'(r_valid), 64'(0));
    chk("post_clear_gnt", 64'(gnt), 64'(1));
    cyc();
    access(1'b1, waddr(5), 32'h0, 4'h0, 8'h56, 4'h0);
    @(negedge clk);
    chk("clear_mem_kept", 64'(r_data), 64'(32'hDEAD_BEAA));
    drain();

    // Random traffic under stalls and random r_ready
    rand_rdy = 1'b1;
    for (int k = 0; k < 1000; k++)
      access(1'($urandom_range(0, 1)), waddr($urandom_range(0, int'(NW) + 3)), $urandom(),
             4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    rand_rdy = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
